vec_mem_responder: RTL and testbench

Memory-side responder for the memory stage's byte-serial access protocol. It accepts one burst request at a time: a scalar access of one item, or a vector access of I consecutive items. Write bursts consume one byte per handshake into an internal byte RAM. Read bursts stream bytes back under valid/ready flow control. It replaces the bare data memory behind the memory stage and adds a completion pulse, out-of-range error reporting, and an optional memory-mapped LED/button window.

---
 rtl/mem_resp_pkg.sv | 26 ++
 rtl/byte_ram.sv | 24 ++
 rtl/vec_mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_vec_mem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types for vec_mem_responder: FSM states, item counter type, IO window offsets.
package mem_resp_pkg;

    localparam int unsigned ITEMS = 20;

    typedef logic [$clog2(ITEMS+1)-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        RADDR = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Where the byte driven in RDATA comes from, decided while in RADDR
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_IO   = 2'd2
    } rd_src_e;

    localparam int unsigned LED_OFS = 0;
    localparam int unsigned BTN_OFS = 1;

endpackage

// File: rtl/byte_ram.sv
// DEPTH x L single-port synchronous RAM, no reset on contents or read register.
// Latency: write on the edge, read data one cycle after the address; no backpressure.
// Backpressure: none, the caller holds addr to keep rdata stable.
module byte_ram #(
    parameter int DEPTH = 1024,
    parameter int L     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [L-1:0]  wdata,
    output logic [L-1:0]  rdata
);

    logic [L-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/vec_mem_responder.sv
// Byte-serial burst responder (scalar or I-item vector) with range errors; optional IO window under MEM_IO_EN.
// Latency: 1 cycle accept, 1 cycle per written byte, 2 cycles per read byte, 1 cycle done pulse.
// Backpressure: wr_valid low stalls WRITE, rd_ready low holds RDATA with rd_data stable; req_ready only in IDLE.
module vec_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int          I       = ITEMS,
    parameter int          L       = 8,
    parameter int          A       = 32,
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] IO_BASE = 32'h0000_1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic         req_vector,
    input  logic [A-1:0] req_address,
    input  logic         wr_valid,
    input  logic [L-1:0] wr_data,
    output logic         wr_ready,
    output logic         rd_valid,
    output logic [L-1:0] rd_data,
    input  logic         rd_ready,
    output logic         done,
    output logic         err,
    input  logic         button_i,
    output logic [L-1:0] leds_o
);

    localparam int AW = $clog2(DEPTH);

    state_e       state;
    rd_src_e      rd_src;
    logic [A-1:0] base;
    logic [A-1:0] addr;
    cnt_t         idx;
    cnt_t         count;
    logic         err_acc;
    logic         done_q;
    logic         err_q;
    logic [L-1:0] io_rd;
    logic [L-1:0] ram_rdata;

    logic         in_ram;
    logic         hit_led;
    logic         hit_btn;
    logic         in_range;
    logic         last;
    logic         wr_fire;
    logic         btn_sync;
    logic [L-1:0] leds_q;

    // Wraps modulo 2^A; only addresses below DEPTH ever reach the RAM
    assign addr     = base + A'(idx);
    assign in_ram   = addr < A'(DEPTH);
    assign in_range = in_ram | hit_led | hit_btn;
    assign last     = (idx == count - 1'b1);
    assign wr_fire  = (state == WRITE) && wr_valid;

`ifdef MEM_IO_EN
    logic btn_meta;

    assign hit_led = (addr == A'(IO_BASE + LED_OFS));
    assign hit_btn = (addr == A'(IO_BASE + BTN_OFS));

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            leds_q   <= '0;
        end else begin
            btn_meta <= button_i;
            btn_sync <= btn_meta;
            if (wr_fire && hit_led)
                leds_q <= wr_data;
        end
    end
`else
    logic unused_io;

    assign hit_led   = 1'b0;
    assign hit_btn   = 1'b0;
    assign btn_sync  = 1'b0;
    assign leds_q    = '0;
    assign unused_io = ^{button_i, IO_BASE};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            rd_src  <= SRC_ZERO;
            base    <= '0;
            idx     <= '0;
            count   <= '0;
            err_acc <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            io_rd   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base    <= req_address;
                        idx     <= '0;
                        count   <= req_vector ? cnt_t'(I) : cnt_t'(1);
                        err_acc <= 1'b0;
                        state   <= req_write ? WRITE : RADDR;
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        if (!in_range)
                            err_acc <= 1'b1;
                        idx <= idx + 1'b1;
                        if (last) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            err_q  <= err_acc | ~in_range;
                        end
                    end
                end
                RADDR: begin
                    // IO value is captured here so rd_data cannot move during a stall
                    if (in_ram)
                        rd_src <= SRC_RAM;
                    else if (hit_led || hit_btn)
                        rd_src <= SRC_IO;
                    else
                        rd_src <= SRC_ZERO;
                    io_rd <= hit_btn ? {{(L-1){1'b0}}, btn_sync} : leds_q;
                    if (!in_range)
                        err_acc <= 1'b1;
                    state <= RDATA;
                end
                RDATA: begin
                    if (rd_ready) begin
                        idx <= idx + 1'b1;
                        if (last) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            err_q  <= err_acc;
                        end else begin
                            state <= RADDR;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    byte_ram #(
        .DEPTH (DEPTH),
        .L     (L),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire && in_ram && rst),
        .addr  (addr[AW-1:0]),
        .wdata (wr_data),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_data = '0;
        if (state == RDATA) begin
            case (rd_src)
                SRC_RAM: rd_data = ram_rdata;
                SRC_IO:  rd_data = io_rd;
                default: rd_data = '0;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign wr_ready  = (state == WRITE);
    assign rd_valid  = (state == RDATA);
    assign done      = done_q;
    assign err       = err_q;
    assign leds_o    = leds_q;

endmodule

// File: tb/tb_vec_mem_responder.sv
// Directed self-checking bench for vec_mem_responder (I=20, L=8, DEPTH=1024).
module tb_vec_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_vector;
    logic [31:0] req_address;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_ready;
    logic        done;
    logic        err;
    logic        button_i;
    logic [7:0]  leds_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] wbuf [20];
    logic [7:0] rexp [20];

    vec_mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_vector  (req_vector),
        .req_address (req_address),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .done        (done),
        .err         (err),
        .button_i    (button_i),
        .leds_o      (leds_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [31:0] a, input logic wr, input logic vec, input string tag);
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = wr;
        req_vector  = vec;
        req_address = a;
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, " busy"}, 32'(req_ready), 32'd0);
    endtask

    task automatic write_burst(input logic [31:0] a, input logic vec, input int n,
                               input logic eerr, input string tag);
        accept(a, 1'b1, vec, tag);
        for (int k = 0; k < n; k++) begin
            chk({tag, " wr_ready"}, 32'(wr_ready), 32'd1);
            if (k > 0)
                chk({tag, " early done"}, 32'(done), 32'd0);
            wr_valid = 1'b1;
            wr_data  = wbuf[k];
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " err"}, 32'(err), 32'(eerr));
        @(negedge clk);
        chk({tag, " done drop"}, 32'(done), 32'd0);
        chk({tag, " idle"}, 32'(req_ready), 32'd1);
    endtask

    task automatic read_burst(input logic [31:0] a, input logic vec, input int n,
                              input logic stall, input logic eerr, input string tag);
        accept(a, 1'b0, vec, tag);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (!rd_valid && w < 4) begin
                @(negedge clk);
                w++;
            end
            chk({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
            chk({tag, " rd_data"}, 32'(rd_data), 32'(rexp[k]));
            if (stall) begin
                @(negedge clk);
                chk({tag, " hold valid"}, 32'(rd_valid), 32'd1);
                chk({tag, " hold data"}, 32'(rd_data), 32'(rexp[k]));
            end
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
            if (k < n - 1)
                chk({tag, " early done"}, 32'(done), 32'd0);
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " err"}, 32'(err), 32'(eerr));
        @(negedge clk);
        chk({tag, " done drop"}, 32'(done), 32'd0);
        chk({tag, " idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst         = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_vector  = 1'b0;
        req_address = '0;
        wr_valid    = 1'b0;
        wr_data     = '0;
        rd_ready    = 1'b0;
        button_i    = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset wr_ready", 32'(wr_ready), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset rd_data", 32'(rd_data), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset leds", 32'(leds_o), 32'd0);
        rst = 1'b1;

        // Scalar write then read back
        wbuf[0] = 8'hA5;
        write_burst(32'd3, 1'b0, 1, 1'b0, "sw3");
        rexp[0] = 8'hA5;
        read_burst(32'd3, 1'b0, 1, 1'b0, 1'b0, "sr3");

        // Vector write 0..19 at 100, stalled vector read
        for (int k = 0; k < 20; k++) begin
            wbuf[k] = 8'(k);
            rexp[k] = 8'(k);
        end
        write_burst(32'd100, 1'b1, 20, 1'b0, "vw100");
        read_burst(32'd100, 1'b1, 20, 1'b1, 1'b0, "vr100");
        read_burst(32'd100, 1'b1, 20, 1'b0, 1'b0, "vr100f");

        // Burst straddling the top of RAM: 5 land, 15 dropped
        for (int k = 0; k < 20; k++) begin
            wbuf[k] = 8'h50 + 8'(k);
            rexp[k] = (k < 5) ? 8'h50 + 8'(k) : 8'h00;
        end
        write_burst(32'd1019, 1'b1, 20, 1'b1, "vwtop");
        read_burst(32'd1019, 1'b1, 20, 1'b0, 1'b1, "vrtop");

        // Reset during a vector write after 7 items
        for (int k = 0; k < 20; k++)
            wbuf[k] = 8'h11;
        write_burst(32'd200, 1'b1, 20, 1'b0, "vwpre");
        accept(32'd200, 1'b1, 1'b1, "vwint");
        for (int k = 0; k < 7; k++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hC0 + 8'(k);
            @(negedge clk);
        end
        wr_valid = 1'b1;
        wr_data  = 8'hC7;
        rst      = 1'b0;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("int idle", 32'(req_ready), 32'd1);
        chk("int done", 32'(done), 32'd0);
        chk("int wr_ready", 32'(wr_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("int no done", 32'(done), 32'd0);
        for (int k = 0; k < 20; k++)
            rexp[k] = (k < 7) ? 8'hC0 + 8'(k) : 8'h11;
        read_burst(32'd200, 1'b1, 20, 1'b0, 1'b0, "vrint");

        // IO window
        button_i = 1'b1;
        repeat (3) @(negedge clk);
        wbuf[0] = 8'h3C;
`ifdef MEM_IO_EN
        write_burst(32'h0000_1000, 1'b0, 1, 1'b0, "ioled");
        chk("io leds", 32'(leds_o), 32'h3C);
        rexp[0] = 8'h01;
        read_burst(32'h0000_1001, 1'b0, 1, 1'b0, 1'b0, "iobtn");
`else
        write_burst(32'h0000_1000, 1'b0, 1, 1'b1, "ioled");
        chk("io leds", 32'(leds_o), 32'h00);
        rexp[0] = 8'h00;
        read_burst(32'h0000_1001, 1'b0, 1, 1'b0, 1'b1, "iobtn");
`endif

        // Earlier RAM data survives the out-of-range traffic
        rexp[0] = 8'hA5;
        read_burst(32'd3, 1'b0, 1, 1'b1, 1'b0, "sr3b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
